// File: rtl/disparity_bram_arbiter.sv
// Serializes stereo-engine writes and UART readout reads onto the shared disparity BRAM.
// Define DISP_ARB_WR_PRIO_EN for writer priority with a reader starvation limit.
module disparity_bram_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              wr_req_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ready_out,
    input  logic              rd_req_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_ready_out,
    output logic              rd_valid_out,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_busy_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_we_out,
    output logic [DATA_W-1:0] bram_din_out,
    input  logic [DATA_W-1:0] bram_dout_in
);

    localparam int DEPTH = READ_LATENCY + 2;

    logic             conflict;
    logic             wr_wins;
    logic             wr_acc;
    logic             rd_acc;
    logic             rd_issue;
    logic [DEPTH-1:0] vpipe;
    logic [DATA_W-1:0] rd_dq;

    assign conflict = wr_req_in & rd_req_in;

`ifdef DISP_ARB_WR_PRIO_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign wr_wins = (starve_cnt != CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            starve_cnt <= '0;
        end else if (rd_acc) begin
            starve_cnt <= '0;
        end else if (conflict && wr_wins) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    // 1 = reader took the previous conflict, so the writer takes the next
    logic last_grant_rd;

    assign wr_wins = last_grant_rd;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant_rd <= 1'b1;
        end else if (conflict) begin
            last_grant_rd <= ~wr_wins;
        end
    end
`endif

    // Readies are forced low while reset is held so no request is taken
    assign wr_ready_out = rst_n_in & (~rd_req_in | wr_wins);
    assign rd_ready_out = rst_n_in & (~wr_req_in | ~wr_wins);

    assign wr_acc = wr_req_in & wr_ready_out;
    assign rd_acc = rd_req_in & rd_ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bram_addr_out <= '0;
            bram_din_out  <= '0;
            bram_we_out   <= 1'b0;
            rd_issue      <= 1'b0;
        end else begin
            bram_we_out <= wr_acc;
            rd_issue    <= rd_acc;
            if (wr_acc) begin
                bram_addr_out <= wr_addr_in;
                bram_din_out  <= wr_data_in;
            end else if (rd_acc) begin
                bram_addr_out <= rd_addr_in;
            end
        end
    end

    // douta for a read is sampled into rd_dq one edge before the strobe
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vpipe       <= '0;
            rd_dq       <= '0;
            rd_data_out <= '0;
        end else begin
            vpipe <= {vpipe[DEPTH-2:0], rd_issue};
            rd_dq <= bram_dout_in;
            if (vpipe[READ_LATENCY]) begin
                rd_data_out <= rd_dq;
            end
        end
    end

    assign rd_valid_out = vpipe[DEPTH-1];
    assign rd_busy_out  = |vpipe;

endmodule

// File: tb/tb_disparity_bram_arbiter.sv
// Randomized bench for disparity_bram_arbiter against a transaction-level model
// of the arbitration rules, a shadow memory and a 2-cycle BRAM.
module tb_disparity_bram_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int LIMIT = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_busy;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;

    disparity_bram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .wr_req_in(wr_req),
        .wr_addr_in(wr_addr),
        .wr_data_in(wr_data),
        .wr_ready_out(wr_ready),
        .rd_req_in(rd_req),
        .rd_addr_in(rd_addr),
        .rd_ready_out(rd_ready),
        .rd_valid_out(rd_valid),
        .rd_data_out(rd_data),
        .rd_busy_out(rd_busy),
        .bram_addr_out(bram_addr),
        .bram_we_out(bram_we),
        .bram_din_out(bram_din),
        .bram_dout_in(bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM with output register: douta follows addra by two edges
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_r1;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem_r1    = '0;
        bram_dout = '0;
        forever begin
            @(posedge clk);
            if (bram_we) mem[bram_addr[7:0]] <= bram_din;
            mem_r1    <= mem[bram_addr[7:0]];
            bram_dout <= mem_r1;
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    int n_checks;
    int n_pass;

    op_t wq[$];
    op_t rq[$];
    rd_t rdq[$];
    logic [DW-1:0] shadow [256];

    int            cyc;
    bit            last_rd_won;
    int            losses;
    logic          wv, rv;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    logic [31:0]   gbits;
    int            gcount;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      tag, got, exp, cyc);
    endtask

    task automatic tick();
        bit  conf, wwin, ew, er, wacc, racc, ev, eb;
        op_t o;
        rd_t e;
        @(negedge clk);
        if (!wv && wq.size() > 0) begin
            o = wq.pop_front();
            wv = 1'b1; wa = o.a; wd = o.d;
        end
        if (!rv && rq.size() > 0) begin
            o = rq.pop_front();
            rv = 1'b1; ra = o.a;
        end
        wr_req  = wv; wr_addr = wa; wr_data = wd;
        rd_req  = rv; rd_addr = ra;
        #1;
        conf = wv && rv;
`ifdef DISP_ARB_WR_PRIO_EN
        wwin = (losses < LIMIT);
`else
        wwin = last_rd_won;
`endif
        ew = !rv || wwin;
        er = !wv || !wwin;
        check("wr_ready", wr_ready, ew);
        check("rd_ready", rd_ready, er);
        wacc = wv && ew;
        racc = rv && er;
        if (conf) begin
            last_rd_won = !wwin;
            if (gcount < 32) gbits[gcount] = wwin;
            gcount++;
        end
        if (racc) losses = 0;
        else if (conf && wwin && losses < LIMIT) losses++;

        @(posedge clk);
        cyc++;
        exp_we = 1'b0;
        if (wacc) begin
            shadow[wa[7:0]] = wd;
            exp_we = 1'b1; exp_addr = wa; exp_din = wd;
            wv = 1'b0;
        end else if (racc) begin
            exp_addr = ra;
            e.due = cyc + 4;
            e.data = shadow[ra[7:0]];
            rdq.push_back(e);
            rv = 1'b0;
        end
        #1;
        check("bram_we", bram_we, exp_we);
        check("bram_addr", bram_addr, exp_addr);
        check("bram_din", bram_din, exp_din);
        eb = rdq.size() > 0 && cyc > rdq[0].due - 4;
        check("rd_busy", rd_busy, eb);
        ev = rdq.size() > 0 && rdq[0].due == cyc;
        check("rd_valid", rd_valid, ev);
        if (ev) begin
            e = rdq.pop_front();
            check("rd_data", rd_data, e.data);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_we", bram_we, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_din", bram_din, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        rdq.delete(); wq.delete(); rq.delete();
        wv = 1'b0; rv = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;
        last_rd_won = 1'b1; losses = 0;
        exp_we = 1'b0; exp_addr = '0; exp_din = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_w(input int a, input int d);
        op_t o;
        o.a = AW'(a); o.d = DW'(d);
        wq.push_back(o);
    endtask

    task automatic push_r(input int a);
        op_t o;
        o.a = AW'(a); o.d = '0;
        rq.push_back(o);
    endtask

    initial begin
        logic [4:0] exp_g;
        n_checks = 0; n_pass = 0; cyc = 0;
        rst_n = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        wa = '0; ra = '0; wd = '0;
        wv = 1'b0; rv = 1'b0;
        gbits = '0; gcount = 0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        do_reset();

        push_w(0, 5); push_w(1, 6); push_w(2, 7);
        repeat (4) tick();
        push_r(1);
        repeat (6) tick();
        check("read_back_addr1", shadow[1], 8'd6);

        do_reset();
        gbits = '0; gcount = 0;
        for (int i = 0; i < 8; i++) push_w(16 + i, 8'h30 + i);
        for (int i = 0; i < 4; i++) push_r(16 + i);
        repeat (16) tick();
`ifdef DISP_ARB_WR_PRIO_EN
        exp_g = 5'b01111;
`else
        exp_g = 5'b10101;
`endif
        check("grant_seq", gbits[4:0], exp_g);

        push_w(9, 8'hAA);
        tick();
        push_r(9);
        repeat (6) tick();

        push_r(3); push_r(4);
        repeat (3) tick();
        do_reset();
        repeat (8) tick();

        for (int n = 0; n < 400; n++) begin
            if (wq.size() == 0 && $urandom_range(2) != 0)
                push_w($urandom_range(15), $urandom_range(255));
            if (rq.size() == 0 && $urandom_range(2) != 0)
                push_r($urandom_range(15));
            tick();
        end
        wq.delete(); rq.delete();
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
